// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pkg                                                                |
// | Shared types and constants for the two-port shared-memory arbiter.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned CNT_W           = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_cmd_t;

    // Write data and byte enables only travel with stores; reads present zeros.
    function automatic mem_cmd_t make_cmd(
        input owner_e      owner,
        input logic [31:0] iaddr,
        input logic        dwe,
        input logic [31:0] daddr,
        input logic [31:0] dwdata,
        input logic [3:0]  dwmask
    );
        mem_cmd_t cmd;
        cmd = '0;
        if (owner == OWN_D) begin
            cmd.we   = dwe;
            cmd.addr = daddr;
            if (dwe) begin
                cmd.wdata = dwdata;
                cmd.wmask = dwmask;
            end
        end else begin
            cmd.addr = iaddr;
        end
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pick                                                               |
// | Combinational owner selection. Fixed D-over-I priority by default;         |
// | round-robin when MEM_ARB_RR_EN is defined.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   ireq_i,
    input  logic   dreq_i,
    input  owner_e last_i,
    output owner_e owner_o
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        owner_o = OWN_D;
        if (ireq_i && dreq_i) begin
            owner_o = (last_i == OWN_D) ? OWN_I : OWN_D;
        end else if (ireq_i) begin
            owner_o = OWN_I;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = last_i;

    always_comb begin
        owner_o = OWN_D;
        if (!dreq_i && ireq_i) begin
            owner_o = OWN_I;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb                                                                    |
// | Arbitrates instruction-fetch and load/store ports onto one memory port,   |
// | with a BUSY timeout. Optional macro: MEM_ARB_RR_EN (round-robin grant).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic        iack,
    output logic [31:0] irdata,

    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwmask,
    output logic        dack,
    output logic [31:0] drdata,

    output logic        err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        hold_o
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    mem_cmd_t         cmd_q, cmd_d;

    owner_e           w_pick;
    owner_e           w_last;
    logic             w_busy;
    logic             w_resp;

`ifdef MEM_ARB_RR_EN
    owner_e last_q, last_d;
    assign w_last = last_q;
`else
    assign w_last = OWN_D;
`endif

    mem_arb_pick u_pick (
        .ireq_i  (ireq),
        .dreq_i  (dreq),
        .last_i  (w_last),
        .owner_o (w_pick)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cmd_d   = cmd_q;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ireq || dreq) begin
                    owner_d = w_pick;
                    cmd_d   = make_cmd(w_pick, iaddr, dwe, daddr, dwdata, dwmask);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = S_BUSY;
`ifdef MEM_ARB_RR_EN
                    last_d  = w_pick;
`endif
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + C_CNT_ONE;
                // A completion landing on the expiry cycle still wins.
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == C_CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_D;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cmd_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_q  <= OWN_D;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cmd_q   <= cmd_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign w_busy = (state_q == S_BUSY);
    assign w_resp = (state_q == S_RESP);

    assign mem_req   = w_busy;
    assign mem_we    = w_busy & cmd_q.we;
    assign mem_addr  = w_busy ? cmd_q.addr  : 32'h0;
    assign mem_wdata = w_busy ? cmd_q.wdata : 32'h0;
    assign mem_wmask = w_busy ? cmd_q.wmask : 4'h0;

    assign iack   = w_resp && (owner_q == OWN_I);
    assign dack   = w_resp && (owner_q == OWN_D);
    assign irdata = iack ? rdata_q : 32'h0;
    assign drdata = dack ? rdata_q : 32'h0;
    assign err    = w_resp & err_q;

    assign hold_o = (ireq & ~iack) | (dreq & ~dack);

endmodule
`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: BUSY cycles without mem_ack before the transaction is aborted (range 2..31).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ireq  in  1  instruction-fetch read request, held until iack.
REQ-005 iaddr  in  32  fetch address.
REQ-006 iack  out  1  one-cycle completion pulse to fetch.
REQ-007 irdata  out  32  fetch read data, valid while iack=1.
REQ-008 dreq  in  1  load/store request, held until dack.
REQ-009 dwe  in  1  1 = store, 0 = load.
REQ-010 daddr / dwdata  in  32 / 32  data address / store data.
REQ-011 dwmask  in  4  store byte enables.
REQ-012 dack  out  1  one-cycle completion pulse to load/store.
REQ-013 drdata  out  32  load data, valid while dack=1.
REQ-014 err  out  1  high with iack/dack when the transaction timed out.
REQ-015 mem_req / mem_we  out  1 / 1  shared-memory request / write enable.
REQ-016 mem_addr / mem_wdata  out  32 / 32  latched address / write data.
REQ-017 mem_wmask  out  4  latched byte enables (0 for reads).
REQ-018 mem_ack  in  1  memory completion pulse; mem_rdata valid with it.
REQ-019 mem_rdata  in  32  memory read data.
REQ-020 hold_o  out  1  pipeline stall request to the controller.

Function
REQ-021 FSM states IDLE, BUSY, RESP; owner register in {I, D}.
REQ-022 IDLE: if any req high, pick owner per REQ-030/031, latch address/we/wdata/wmask, go to BUSY; else stay in IDLE.
REQ-023 BUSY: mem_req=1 with latched fields held stable; on mem_ack, capture mem_rdata and go to RESP.
REQ-024 RESP: owner's ack=1 for exactly one cycle with the captured data; then IDLE.
REQ-025 Latency: req sampled in IDLE at cycle 0, mem_req at cycle 1, owner ack at cycle N+2 where N = memory wait cycles (zero-wait gives 2).
REQ-026 Timeout: 5-bit counter cleared on BUSY entry, incremented each BUSY cycle; at TIMEOUT without mem_ack, drop mem_req, go to RESP with err=1 and rdata=0.
REQ-027 mem_ack arriving in the same cycle as timeout expiry counts as a success (err=0).
REQ-028 Requester dropping req mid-transaction does not abort it; ack is still pulsed.
REQ-029 mem_ack outside BUSY is ignored.
REQ-030 Fixed policy (macro absent): dreq beats ireq when both are high in IDLE.
REQ-031 hold_o = (ireq & ~iack) | (dreq & ~dack), combinational.
REQ-032 Non-owner ack, data and err outputs are 0; mem_* outputs are 0 outside BUSY.

Reset
REQ-033 On rst: state IDLE, counter 0, all outputs 0, last-grant = D; applies mid-transaction, with no ack issued for the aborted access.

Configuration
REQ-034 Macro MEM_ARB_RR_EN: if defined, arbitration is round-robin: with both requests pending, grant the side not granted last (last-grant updated on BUSY entry); if undefined, use fixed priority per REQ-030 and no last-grant register.

Structure
REQ-035 Package mem_arb_pkg holds the state enum, the owner enum and the TIMEOUT default constant.
REQ-036 Sub-module mem_arb_pick, purely combinational: inputs ireq, dreq, last-grant; output chosen owner; contains the macro-dependent policy.

Verification
REQ-037 ireq only, iaddr=0x100, mem_ack 0 wait, mem_rdata=0x00000013 -> mem_req at cycle 1, iack=1 with irdata=0x13 at cycle 2, err=0.
REQ-038 dreq store, daddr=0x2000, dwdata=0xDEADBEEF, dwmask=0xF, ack after 3 waits -> mem_we=1, fields stable 4 cycles, dack at cycle 5.
REQ-039 ireq and dreq together, twice back-to-back -> fixed: D,I,D; with MEM_ARB_RR_EN: I,D,I (reset last-grant = D).
REQ-040 No mem_ack, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles, ack pulses with err=1 and data 0.
REQ-041 rst asserted in BUSY, then mem_ack arrives -> IDLE, no ack pulses, mem_req=0 the next cycle.
REQ-042 mem_ack in the cycle the counter reaches TIMEOUT -> ack with err=0 and valid data.
